// File: rtl/maxpool_layer_1.sv
// maxpool_layer_1
//   2x2 / stride-2 max pooling of the 1-bit conv1 feature maps. With binary
//   activations the max of a window is the OR of its four pixels. Pixels
//   arrive one position per valid_in cycle in row-major order, all CH channels
//   side by side. Even rows leave their horizontal-pair ORs in a half-width
//   line buffer. Odd rows combine that buffer with their own pairs to emit one
//   pooled pixel per window.
//
//   Ports
//     clk        system clock, rising edge
//     rst        asynchronous, active-high reset
//     pix_in     [CH]  one pixel position, bit i = conv1 channel i+1
//     valid_in   pix_in valid this cycle (may drop for any number of cycles)
//     pool_out   [CH]  pooled pixel, bit i = channel i+1 (holds between pulses)
//     valid_out  1-cycle pulse per pooled pixel, 1 cycle after the window's
//                bottom-right pixel
//     frame_done 1-cycle pulse, 1 cycle after the last pixel of a frame

// One channel's datapath. It holds the pair register, its slice of the line
// buffer and its output bit.
module maxpool_lane #(
   parameter int HW = 13,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_in,
   input  logic          pix,
   input  logic          col_odd,
   input  logic          row_odd,
   input  logic [AW-1:0] addr,
   output logic          pool
);
   logic          hold;
   logic          hpair;
   logic [HW-1:0] linebuf;

   assign hpair = hold | pix;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= 1'b0;
         pool <= 1'b0;
      end else if (valid_in) begin
         if (!col_odd)
            hold <= pix;
         else if (row_odd)
            pool <= linebuf[addr] | hpair;
      end
   end

   // No reset is needed here. Each even row rewrites every entry before the
   // following odd row reads it.
   always_ff @(posedge clk) begin
      if (valid_in && col_odd && !row_odd)
         linebuf[addr] <= hpair;
   end
endmodule

module maxpool_layer_1 #(
   parameter int IN_W = 26,
   parameter int IN_H = 26,
   parameter int CH   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] pix_in,
   input  logic          valid_in,
   output logic [CH-1:0] pool_out,
   output logic          valid_out,
   output logic          frame_done
);
   localparam int CW = $clog2(IN_W);
   localparam int RW = $clog2(IN_H);
   localparam int HW = IN_W / 2;
   localparam int AW = CW - 1;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          last_col;
   logic          last_row;

   assign last_col = (col == CW'(IN_W - 1));
   assign last_row = (row == RW'(IN_H - 1));

   // Position counters and the output pulses. With odd IN_W, the last column
   // has an even index, so it only loads hold and is never paired. With odd
   // IN_H, the last row has an even index, so it only fills the buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= valid_in & row[0] & col[0];
         frame_done <= valid_in & last_col & last_row;
         if (valid_in) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_lane
      maxpool_lane #(.HW(HW), .AW(AW)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .valid_in (valid_in),
         .pix      (pix_in[i]),
         .col_odd  (col[0]),
         .row_odd  (row[0]),
         .addr     (col[CW-1:1]),
         .pool     (pool_out[i])
      );
   end
endmodule

// File: tb/tb_maxpool_layer_1.sv
module tb_maxpool_layer_1;
   localparam int W  = 26;
   localparam int H  = 26;
   localparam int N  = W * H;
   localparam int PW = W / 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pix_in;
   logic       valid_in;
   logic [7:0] pool_out;
   logic       valid_out;
   logic       frame_done;

   int total = 0;
   int bad   = 0;

   // Reference state: the frame being sent, the position of the next accepted
   // pixel, and the last pooled value the bench expects to see held.
   logic [7:0] fmem [N];
   int         k;
   logic [7:0] last_exp;
   int         pulses, fds, nz_cnt, nz_idx;

   maxpool_layer_1 #(.IN_W(W), .IN_H(H), .CH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix_in),
      .valid_in   (valid_in),
      .pool_out   (pool_out),
      .valid_out  (valid_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] win(input int pr, input int pc);
      int r0, c0;
      r0 = 2 * pr;
      c0 = 2 * pc;
      return fmem[r0*W + c0] | fmem[r0*W + c0 + 1] |
             fmem[(r0+1)*W + c0] | fmem[(r0+1)*W + c0 + 1];
   endfunction

   // Runs one clock cycle. When v is set, it advances the reference position
   // and checks the outputs that pixel must produce.
   task automatic step(input logic v, input logic [7:0] p);
      logic       ev, efd;
      logic [7:0] ep;
      int         r, c;
      valid_in = v;
      pix_in   = p;
      ev  = 1'b0;
      efd = 1'b0;
      ep  = last_exp;
      if (v) begin
         r = k / W;
         c = k % W;
         if ((r % 2 == 1) && (c % 2 == 1)) begin
            ev = 1'b1;
            ep = win(r / 2, c / 2);
         end
         efd = (k == N - 1);
         k   = (k == N - 1) ? 0 : k + 1;
      end
      @(posedge clk);
      #1;
      chk("valid_out", 32'(valid_out), 32'(ev));
      chk("frame_done", 32'(frame_done), 32'(efd));
      chk(ev ? "pool_out" : "pool_out_hold", 32'(pool_out), 32'(ep));
      if (valid_out) begin
         if (pool_out != 8'h00) begin
            nz_cnt++;
            nz_idx = pulses;
         end
         pulses++;
      end
      if (frame_done) fds++;
      last_exp = ep;
   endtask

   task automatic fill(input int mode);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            logic [7:0] b;
            b = 8'h00;
            case (mode)
               1: b = 8'hFF;
               2: b = (r == 3 && c == 5) ? 8'h04 : 8'h00;
               3: for (int i = 0; i < 8; i++) b[i] = ((r + c + i) % 2) == 1;
               4: b = (r % 2 == 0 && c % 2 == 0) ? 8'h80 : 8'h00;
               5: b = 8'($urandom) & 8'($urandom);
               default: b = 8'h00;
            endcase
            fmem[r*W + c] = b;
         end
   endtask

   task automatic clr_stats();
      pulses = 0;
      fds    = 0;
      nz_cnt = 0;
      nz_idx = -1;
   endtask

   task automatic send(input int n, input int stall_pct);
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(99) < stall_pct) step(1'b0, 8'($urandom));
         step(1'b1, fmem[k]);
      end
   endtask

   task automatic frame(input string tag, input int mode, input int stall_pct);
      fill(mode);
      clr_stats();
      send(N, stall_pct);
      chk({tag, "_pulses"}, 32'(pulses), 32'(PW * (H / 2)));
      chk({tag, "_frame_done"}, 32'(fds), 32'd1);
   endtask

   initial begin
      rst      = 1'b1;
      valid_in = 1'b0;
      pix_in   = 8'h00;
      k        = 0;
      last_exp = 8'h00;
      clr_stats();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pool_out", 32'(pool_out), 32'h0);
      chk("rst_valid_out", 32'(valid_out), 32'h0);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
      rst = 1'b0;
      step(1'b0, 8'h00);

      frame("zeros", 0, 0);
      chk("zeros_nonzero", 32'(nz_cnt), 32'd0);

      frame("single", 2, 0);
      chk("single_nz_cnt", 32'(nz_cnt), 32'd1);
      chk("single_nz_idx", 32'(nz_idx), 32'd15);

      frame("checker", 3, 0);
      frame("ch8_even", 4, 0);

      frame("single_stall", 2, 40);
      chk("stall_nz_cnt", 32'(nz_cnt), 32'd1);
      chk("stall_nz_idx", 32'(nz_idx), 32'd15);

      frame("random", 5, 25);

      // Frame A (all 1s) followed by frame B (all 0s) with no idle cycle.
      // The buffer is swapped only after A's last pixel has been checked.
      clr_stats();
      fill(1);
      send(N, 0);
      chk("b2b_a_pulses", 32'(pulses), 32'd169);
      chk("b2b_a_fd", 32'(fds), 32'd1);
      chk("b2b_a_nonff", 32'(nz_cnt), 32'd169);
      clr_stats();
      fill(0);
      send(N, 0);
      chk("b2b_b_pulses", 32'(pulses), 32'd169);
      chk("b2b_b_fd", 32'(fds), 32'd1);
      chk("b2b_b_nonzero", 32'(nz_cnt), 32'd0);

      // Reset in the middle of a frame. The outputs must clear without a
      // clock edge, and the next frame restarts at pixel (0,0).
      fill(1);
      clr_stats();
      send(300, 0);
      valid_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_pool_out", 32'(pool_out), 32'h0);
      chk("midrst_valid_out", 32'(valid_out), 32'h0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      k        = 0;
      last_exp = 8'h00;
      frame("post_rst", 1, 10);
      chk("post_rst_allff", 32'(nz_cnt), 32'd169);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
